// File: rtl/iso16_trace_replayer.sv
// Replays an ISO-16 True Delivery Loop trace: reassembles 32-bit trace records, holds each
// for its recorded cycle delta, then commits all replayed loop signals in one edge.
module iso16_trace_replayer #(
    parameter bit          SEAL_START_PULSE = 1'b1,
    parameter int unsigned STALL_CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [31:0]            s_data_i,
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    output logic [3:0]             state_o,
    output logic [31:0]            cycle_o,
    output logic [31:0]            warp_sum_x_o,
    output logic [31:0]            error_sum_o,
    output logic                   symmetry_ok_o,
    output logic                   error_ok_o,
    output logic                   true_delivery_o,
    output logic                   seal_start_o,
    output logic                   seal_ready_o,
    output logic [255:0]           seal_out_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StWarp,
        StErr,
        StSeal,
        StWait,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Staging registers: filled word by word, invisible on the outputs until commit.
    logic [15:0]  hdr_q, hdr_d;
    logic [15:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0]  warp_stg_q, warp_stg_d;
    logic [31:0]  err_stg_q, err_stg_d;
    logic [255:0] seal_stg_q, seal_stg_d;
    logic [2:0]   seal_idx_q, seal_idx_d;

    // Committed output registers.
    logic [3:0]             rstate_q, rstate_d;
    logic [31:0]            cycle_q, cycle_d;
    logic [31:0]            warp_q, warp_d;
    logic [31:0]            err_q, err_d;
    logic                   sym_ok_q, sym_ok_d;
    logic                   err_ok_q, err_ok_d;
    logic                   true_del_q, true_del_d;
    logic                   seal_start_q, seal_start_d;
    logic                   seal_ready_q, seal_ready_d;
    logic [255:0]           seal_q, seal_d;
    logic                   done_q, done_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    logic busy;
    logic ready;

    assign busy  = (state_q != StIdle) && (state_q != StDone);
    assign ready = (state_q == StHdr) || (state_q == StWarp) ||
                   (state_q == StErr) || (state_q == StSeal);

    always_comb begin
        state_d      = state_q;
        hdr_d        = hdr_q;
        wait_cnt_d   = wait_cnt_q;
        warp_stg_d   = warp_stg_q;
        err_stg_d    = err_stg_q;
        seal_stg_d   = seal_stg_q;
        seal_idx_d   = seal_idx_q;
        rstate_d     = rstate_q;
        cycle_d      = cycle_q;
        warp_d       = warp_q;
        err_d        = err_q;
        sym_ok_d     = sym_ok_q;
        err_ok_d     = err_ok_q;
        true_del_d   = true_del_q;
        seal_start_d = seal_start_q;
        seal_ready_d = seal_ready_q;
        seal_d       = seal_q;
        done_d       = done_q;
        stall_d      = stall_q;

        if (SEAL_START_PULSE) begin
            seal_start_d = 1'b0;
        end
        if (busy) begin
            cycle_d = cycle_q + 32'd1;
        end
        if (((state_q == StWarp) || (state_q == StErr) || (state_q == StSeal)) &&
            !s_valid_i && (stall_q != {STALL_CNT_W{1'b1}})) begin
            stall_d = stall_q + STALL_CNT_W'(1);
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    state_d = StHdr;
                    cycle_d = '0;
                    stall_d = '0;
                    done_d  = 1'b0;
                end
            end
            StHdr: begin
                if (s_valid_i) begin
                    hdr_d      = s_data_i[15:0];
                    wait_cnt_d = s_data_i[31:16];
                    state_d    = StWarp;
                end
            end
            StWarp: begin
                if (s_valid_i) begin
                    warp_stg_d = s_data_i;
                    state_d    = StErr;
                end
            end
            StErr: begin
                if (s_valid_i) begin
                    err_stg_d  = s_data_i;
                    seal_idx_d = 3'd0;
                    state_d    = hdr_q[15] ? StSeal : StWait;
                end
            end
            StSeal: begin
                if (s_valid_i) begin
                    seal_stg_d[32*seal_idx_q +: 32] = s_data_i;
                    seal_idx_d = seal_idx_q + 3'd1;
                    if (seal_idx_q == 3'd7) begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (wait_cnt_q == 16'd0) begin
                    rstate_d     = hdr_q[3:0];
                    seal_start_d = hdr_q[4];
                    seal_ready_d = hdr_q[5];
                    sym_ok_d     = hdr_q[6];
                    err_ok_d     = hdr_q[7];
                    true_del_d   = hdr_q[8];
                    warp_d       = warp_stg_q;
                    err_d        = err_stg_q;
                    if (hdr_q[15]) begin
                        seal_d = seal_stg_q;
                    end
                    if (hdr_q[14]) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StHdr;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q - 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            hdr_q        <= '0;
            wait_cnt_q   <= '0;
            warp_stg_q   <= '0;
            err_stg_q    <= '0;
            seal_stg_q   <= '0;
            seal_idx_q   <= '0;
            rstate_q     <= '0;
            cycle_q      <= '0;
            warp_q       <= '0;
            err_q        <= '0;
            sym_ok_q     <= 1'b0;
            err_ok_q     <= 1'b0;
            true_del_q   <= 1'b0;
            seal_start_q <= 1'b0;
            seal_ready_q <= 1'b0;
            seal_q       <= '0;
            done_q       <= 1'b0;
            stall_q      <= '0;
        end else begin
            state_q      <= state_d;
            hdr_q        <= hdr_d;
            wait_cnt_q   <= wait_cnt_d;
            warp_stg_q   <= warp_stg_d;
            err_stg_q    <= err_stg_d;
            seal_stg_q   <= seal_stg_d;
            seal_idx_q   <= seal_idx_d;
            rstate_q     <= rstate_d;
            cycle_q      <= cycle_d;
            warp_q       <= warp_d;
            err_q        <= err_d;
            sym_ok_q     <= sym_ok_d;
            err_ok_q     <= err_ok_d;
            true_del_q   <= true_del_d;
            seal_start_q <= seal_start_d;
            seal_ready_q <= seal_ready_d;
            seal_q       <= seal_d;
            done_q       <= done_d;
            stall_q      <= stall_d;
        end
    end

    assign s_ready_o       = ready;
    assign state_o         = rstate_q;
    assign cycle_o         = cycle_q;
    assign warp_sum_x_o    = warp_q;
    assign error_sum_o     = err_q;
    assign symmetry_ok_o   = sym_ok_q;
    assign error_ok_o      = err_ok_q;
    assign true_delivery_o = true_del_q;
    assign seal_start_o    = seal_start_q;
    assign seal_ready_o    = seal_ready_q;
    assign seal_out_o      = seal_q;
    assign busy_o          = busy;
    assign done_o          = done_q;
    assign stall_cnt_o     = stall_q;

endmodule

// File: tb/tb_iso16_trace_replayer.sv
// Scoreboard bench for iso16_trace_replayer: the driver queues each record's expected commit,
// a negedge monitor compares the outputs on the commit edge.
module tb_iso16_trace_replayer;

    localparam int unsigned StallW = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_i = 1'b0;
    logic [31:0]       s_data_i = '0;
    logic              s_valid_i = 1'b0;
    logic              s_ready_o;
    logic [3:0]        state_o;
    logic [31:0]       cycle_o;
    logic [31:0]       warp_sum_x_o;
    logic [31:0]       error_sum_o;
    logic              symmetry_ok_o;
    logic              error_ok_o;
    logic              true_delivery_o;
    logic              seal_start_o;
    logic              seal_ready_o;
    logic [255:0]      seal_out_o;
    logic              busy_o;
    logic              done_o;
    logic [StallW-1:0] stall_cnt_o;

    iso16_trace_replayer #(
        .SEAL_START_PULSE(1'b1),
        .STALL_CNT_W     (StallW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .s_data_i       (s_data_i),
        .s_valid_i      (s_valid_i),
        .s_ready_o      (s_ready_o),
        .state_o        (state_o),
        .cycle_o        (cycle_o),
        .warp_sum_x_o   (warp_sum_x_o),
        .error_sum_o    (error_sum_o),
        .symmetry_ok_o  (symmetry_ok_o),
        .error_ok_o     (error_ok_o),
        .true_delivery_o(true_delivery_o),
        .seal_start_o   (seal_start_o),
        .seal_ready_o   (seal_ready_o),
        .seal_out_o     (seal_out_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    always #5 clk = ~clk;

    int unsigned edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int unsigned  at;
        logic [3:0]   st;
        logic [31:0]  cyc;
        logic [31:0]  warp;
        logic [31:0]  err;
        logic         sym;
        logic         eok;
        logic         td;
        logic         sstart;
        logic         sready;
        logic [255:0] seal;
        logic         done;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [255:0] m_seal = '0;
    logic [31:0] last_warp = '0;
    int unsigned start_edge = 0;
    int unsigned commit_at = 0;
    int unsigned t_acc = 0;
    logic [31:0] seal_w[8];
    logic [31:0] no_seal[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic check_seal(input string name, input logic [255:0] act,
                              input logic [255:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: on the commit edge compare everything; one edge earlier the old warp must hold.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            if (exp_q[0].at == edge_cnt + 1) begin
                check("pre_commit_warp", warp_sum_x_o, last_warp);
            end else if (exp_q[0].at == edge_cnt) begin
                e = exp_q.pop_front();
                check("commit_state", 32'(state_o), 32'(e.st));
                check("commit_cycle", cycle_o, e.cyc);
                check("commit_warp", warp_sum_x_o, e.warp);
                check("commit_err", error_sum_o, e.err);
                check("commit_sym", 32'(symmetry_ok_o), 32'(e.sym));
                check("commit_eok", 32'(error_ok_o), 32'(e.eok));
                check("commit_td", 32'(true_delivery_o), 32'(e.td));
                check("commit_sstart", 32'(seal_start_o), 32'(e.sstart));
                check("commit_sready", 32'(seal_ready_o), 32'(e.sready));
                check_seal("commit_seal", seal_out_o, e.seal);
                check("commit_done", 32'(done_o), 32'(e.done));
                check("commit_busy", 32'(busy_o), 32'(!e.done));
                last_warp = e.warp;
            end else if (exp_q[0].at < edge_cnt) begin
                n_cmp++;
                n_fail++;
                $display("FAIL commit_missed: edge %0d passed, required commit at %0d",
                         edge_cnt, exp_q[0].at);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic send_word(input logic [31:0] w);
        int guard = 0;
        s_data_i  = w;
        s_valid_i = 1'b1;
        while (!s_ready_o) begin
            @(negedge clk);
            guard++;
            if (guard > 100) begin
                $display("FAIL send_word_timeout: s_ready_o stuck at 0, required 1");
                $fatal(1, "handshake timeout");
            end
        end
        @(negedge clk);
    endtask

    // Called at the negedge following the record's last accepted word.
    task automatic push_exp(input logic [31:0] hdr, input logic [31:0] warp,
                            input logic [31:0] err, input logic [31:0] sw[8]);
        exp_t e;
        t_acc = edge_cnt;
        if (hdr[15]) begin
            for (int k = 0; k < 8; k++) m_seal[32*k +: 32] = sw[k];
        end
        e.at     = edge_cnt + 1 + 32'(hdr[31:16]);
        e.cyc    = e.at - start_edge;
        e.st     = hdr[3:0];
        e.warp   = warp;
        e.err    = err;
        e.sstart = hdr[4];
        e.sready = hdr[5];
        e.sym    = hdr[6];
        e.eok    = hdr[7];
        e.td     = hdr[8];
        e.seal   = m_seal;
        e.done   = hdr[14];
        commit_at = e.at;
        exp_q.push_back(e);
    endtask

    task automatic send_record(input logic [31:0] hdr, input logic [31:0] warp,
                               input logic [31:0] err, input logic [31:0] sw[8]);
        send_word(hdr);
        send_word(warp);
        send_word(err);
        if (hdr[15]) begin
            for (int k = 0; k < 8; k++) send_word(sw[k]);
        end
        s_valid_i = 1'b0;
        push_exp(hdr, warp, err, sw);
    endtask

    task automatic wait_commit();
        while (edge_cnt < commit_at) @(negedge clk);
    endtask

    task automatic do_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i    = 1'b0;
        start_edge = edge_cnt;
        check("start_cycle_clear", cycle_o, 32'd0);
        check("start_done_clear", 32'(done_o), 32'd0);
        check("start_stall_clear", 32'(stall_cnt_o), 32'd0);
        check("start_busy", 32'(busy_o), 32'd1);
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            no_seal[k] = '0;
            seal_w[k]  = 32'(k);
        end

        // Reset, then idle with valid high: nothing may move.
        s_valid_i = 1'b1;
        s_data_i  = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_cycle", cycle_o, 32'd0);
        check("rst_warp", warp_sum_x_o, 32'd0);
        check("rst_err", error_sum_o, 32'd0);
        check("rst_flags", {27'd0, symmetry_ok_o, error_ok_o, true_delivery_o, seal_start_o,
                            seal_ready_o}, 32'd0);
        check_seal("rst_seal", seal_out_o, 256'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_stall", 32'(stall_cnt_o), 32'd0);
        check("rst_ready", 32'(s_ready_o), 32'd0);
        s_valid_i = 1'b0;

        do_start();

        // Record A: delta 3, ready stays low for three cycles after the last accept.
        send_record(32'h0003_00C5, 32'h0000_1234, 32'h0000_0010, no_seal);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("hold_ready_low", 32'(s_ready_o), 32'd0);
        end
        @(negedge clk);
        check("a_ready_after_commit", 32'(s_ready_o), 32'd1);
        check("a_commit_edge", edge_cnt - t_acc, 32'd4);
        check("a_state", 32'(state_o), 32'h5);

        // Record B: seal present, delta 0, seal_start pulses once.
        send_record(32'h0000_8015, 32'h0000_B00B, 32'h0000_000B, seal_w);
        @(negedge clk);
        check("b_sstart_high", 32'(seal_start_o), 32'd1);
        check_seal("b_seal", seal_out_o, {32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1,
                                          32'h0});
        @(negedge clk);
        check("b_sstart_low", 32'(seal_start_o), 32'd0);

        // Record C: no seal, seal_out_o must keep record B's value.
        send_record(32'h0001_0042, 32'h0000_0C0C, 32'h0000_000C, no_seal);
        wait_commit();

        // Record D: 5-cycle stall between warp and err words.
        send_word(32'h0000_0103);
        send_word(32'hAAAA_5555);
        s_valid_i = 1'b0;
        repeat (5) @(negedge clk);
        check("d_stall_mid", 32'(stall_cnt_o), 32'd5);
        check("d_warp_untouched", warp_sum_x_o, 32'h0000_0C0C);
        send_word(32'h0000_DEAD);
        s_valid_i = 1'b0;
        push_exp(32'h0000_0103, 32'hAAAA_5555, 32'h0000_DEAD, no_seal);
        wait_commit();
        check("d_stall_commit", 32'(stall_cnt_o), 32'd5);
        repeat (4) @(negedge clk);
        check("d_stall_hdr_not_counted", 32'(stall_cnt_o), 32'd5);

        // Record E: end of trace.
        send_record(32'h0002_4106, 32'h0000_0001, 32'h0000_0002, no_seal);
        wait_commit();
        check("e_done", 32'(done_o), 32'd1);
        check("e_busy", 32'(busy_o), 32'd0);
        check("e_ready", 32'(s_ready_o), 32'd0);
        repeat (3) @(negedge clk);
        check("e_cycle_frozen", cycle_o, commit_at - start_edge);
        check("e_state_hold", 32'(state_o), 32'h6);

        do_start();

        // Record F: reset lands while seal word 4 is on the bus.
        send_word(32'h0000_8001);
        send_word(32'h0000_F0F0);
        send_word(32'h0000_000F);
        for (int k = 0; k < 4; k++) send_word(32'h100 + 32'(k));
        s_data_i = 32'h0000_0104;
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_state", 32'(state_o), 32'd0);
        check("rst_mid_warp", warp_sum_x_o, 32'd0);
        check("rst_mid_err", error_sum_o, 32'd0);
        check_seal("rst_mid_seal", seal_out_o, 256'd0);
        check("rst_mid_busy", 32'(busy_o), 32'd0);
        check("rst_mid_ready", 32'(s_ready_o), 32'd0);
        check("rst_mid_cycle", cycle_o, 32'd0);
        check("rst_mid_done", 32'(done_o), 32'd0);
        m_seal    = '0;
        last_warp = '0;
        @(negedge clk);
        rst_n     = 1'b1;
        s_valid_i = 1'b0;
        @(negedge clk);

        do_start();
        send_record(32'h0000_0087, 32'h0000_0077, 32'h0000_0007, no_seal);
        wait_commit();
        for (int k = 0; k < 8; k++) seal_w[k] = 32'h5000 + 32'(k);
        send_record(32'h0000_C030, 32'h0000_0055, 32'h0000_0005, seal_w);
        wait_commit();
        repeat (2) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
